// File: rtl/pong_pkg.sv
// pong_pkg: types and 640x480 timing constants shared by vga_sync and vga_sync_decoder.
// Ports: none. Provides sync_data_t, init_speed_t, dec_state_e, timing constants,
//   the decoder counter width, and a sync polarity normalisation helper.
package pong_pkg;

  // Sync bundle as produced by vga_sync and consumed by the decoder.
  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic video_on;
  } sync_data_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } init_speed_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } dec_state_e;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int               CNT_W   = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Returns 1 when the sync line is in its asserted state.
  function automatic logic sync_active(input logic level, input logic active_low);
    return active_low ? ~level : level;
  endfunction

endpackage

// File: rtl/sync_axis_counter.sv
// sync_axis_counter: leading-edge detect, saturating 11-bit position counter, length check.
// Ports: step_i advances all state; sync_act_i is the normalised sync level; check_i enables
//   the length check; cnt_nxt_o, edge_o and len_err_o are this step's combinational results.
module sync_axis_counter
  import pong_pkg::*;
#(
  parameter int TOTAL = 800
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             step_i,
  input  logic             sync_act_i,
  input  logic             check_i,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             edge_o,
  output logic             len_err_o
);

  localparam logic [CNT_W:0] LEN = (CNT_W+1)'(TOTAL);

  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;

  assign edge_o = step_i && sync_act_i && !r_prev;

  // A clean period covers counts 0..TOTAL-1, so the count seen at the restart is TOTAL-1.
  assign len_err_o = edge_o && check_i && (({1'b0, r_cnt} + 1'b1) != LEN);

  always_comb begin
    cnt_nxt_o = r_cnt;
    if (edge_o) begin
      cnt_nxt_o = '0;
    end else if (step_i && (r_cnt != CNT_MAX)) begin
      cnt_nxt_o = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else if (step_i) begin
      r_prev <= sync_act_i;
      r_cnt  <= cnt_nxt_o;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position from h_sync/v_sync/video_on and checks timing lock.
// Ports: clk_i/rst_n_i (sync, active-low), pix_en_i pixel tick, sync_i bundle under test;
//   outputs are registered and describe the pixel sampled on the previous pix_en tick.
module vga_sync_decoder
  import pong_pkg::*;
#(
  parameter int H_VISIBLE       = VGA_H_VISIBLE,
  parameter int H_FRONT         = VGA_H_FRONT,
  parameter int H_SYNC          = VGA_H_SYNC,
  parameter int H_BACK          = VGA_H_BACK,
  parameter int V_VISIBLE       = VGA_V_VISIBLE,
  parameter int V_FRONT         = VGA_V_FRONT,
  parameter int V_SYNC          = VGA_V_SYNC,
  parameter int V_BACK          = VGA_V_BACK,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pix_en_i,
  input  sync_data_t sync_i,
  output logic [9:0] pos_x_o,
  output logic [9:0] pos_y_o,
  output logic       pos_valid_o,
  output logic       frame_start_o,
  output logic       locked_o,
  output logic       h_len_err_o,
  output logic       v_len_err_o,
  output logic       de_err_o,
  output logic [7:0] err_cnt_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  dec_state_e       r_state, w_state_nxt;
  logic [3:0]       r_good, w_good_nxt;
  logic             w_h_act, w_v_act, w_check;
  logic [CNT_W-1:0] w_h_cnt_nxt, w_v_cnt_nxt;
  logic             w_h_edge, w_v_edge, w_h_err, w_v_err;
  logic [CNT_W-1:0] w_x, w_y;
  logic             w_vis, w_lock_nxt, w_de_err, w_fs;
  logic [8:0]       w_err_sum;
  logic [7:0]       w_err_nxt;

  logic [9:0] r_pos_x, r_pos_y;
  logic       r_pos_valid, r_fs, r_h_err, r_v_err, r_de_err;
  logic [7:0] r_err_cnt;

  assign w_h_act = sync_active(sync_i.h_sync, SYNC_ACTIVE_LOW != 0);
  assign w_v_act = sync_active(sync_i.v_sync, SYNC_ACTIVE_LOW != 0);
  assign w_check = (r_state != UNLOCKED);

  sync_axis_counter #(.TOTAL(H_TOTAL)) u_h_axis (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .step_i     (pix_en_i),
    .sync_act_i (w_h_act),
    .check_i    (w_check),
    .cnt_nxt_o  (w_h_cnt_nxt),
    .edge_o     (w_h_edge),
    .len_err_o  (w_h_err)
  );

  // The vertical axis only sees v_sync at horizontal leading edges, so it counts lines.
  sync_axis_counter #(.TOTAL(V_TOTAL)) u_v_axis (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .step_i     (w_h_edge),
    .sync_act_i (w_v_act),
    .check_i    (w_check),
    .cnt_nxt_o  (w_v_cnt_nxt),
    .edge_o     (w_v_edge),
    .len_err_o  (w_v_err)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= UNLOCKED;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
    end
  end

  // Errors take priority over a frame completing, so an error on the final
  // acquisition frame still lands in UNLOCKED.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    case (r_state)
      UNLOCKED: begin
        if (w_v_edge) begin
          w_state_nxt = ACQUIRE;
          w_good_nxt  = '0;
        end
      end
      ACQUIRE: begin
        if (w_h_err || w_v_err) begin
          w_state_nxt = UNLOCKED;
        end else if (w_v_edge) begin
          w_good_nxt = r_good + 4'd1;
          if (({1'b0, r_good} + 5'd1) == 5'(LOCK_FRAMES)) begin
            w_state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (w_h_err || w_v_err) begin
          w_state_nxt = UNLOCKED;
        end
      end
      default: w_state_nxt = UNLOCKED;
    endcase
  end

  // Window tests use unsigned wrap: counts before the visible start wrap to large values.
  always_comb begin
    w_x        = w_h_cnt_nxt - CNT_W'(H_SYNC + H_BACK);
    w_y        = w_v_cnt_nxt - CNT_W'(V_SYNC + V_BACK);
    w_vis      = (w_x < CNT_W'(H_VISIBLE)) && (w_y < CNT_W'(V_VISIBLE));
    w_lock_nxt = (w_state_nxt == LOCKED);
    w_de_err   = pix_en_i && w_lock_nxt && (sync_i.video_on != w_vis);
    w_fs       = pix_en_i && w_lock_nxt && (w_x == '0) && (w_y == '0);
    w_err_sum  = {1'b0, r_err_cnt} + 9'(w_h_err) + 9'(w_v_err) + 9'(w_de_err);
    w_err_nxt  = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_pos_valid <= 1'b0;
      r_fs        <= 1'b0;
      r_h_err     <= 1'b0;
      r_v_err     <= 1'b0;
      r_de_err    <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      // Pulses are rewritten every clk so they never outlast one cycle.
      r_fs     <= w_fs;
      r_h_err  <= w_h_err;
      r_v_err  <= w_v_err;
      r_de_err <= w_de_err;
      if (pix_en_i) begin
        r_pos_x     <= w_x[9:0];
        r_pos_y     <= w_y[9:0];
        r_pos_valid <= w_lock_nxt && w_vis;
        r_err_cnt   <= w_err_nxt;
      end
    end
  end

  assign pos_x_o       = r_pos_x;
  assign pos_y_o       = r_pos_y;
  assign pos_valid_o   = r_pos_valid;
  assign frame_start_o = r_fs;
  assign locked_o      = (r_state == LOCKED);
  assign h_len_err_o   = r_h_err;
  assign v_len_err_o   = r_v_err;
  assign de_err_o      = r_de_err;
  assign err_cnt_o     = r_err_cnt;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed frames on a reduced 15x11 timing, compared each clk with a model.
module tb_vga_sync_decoder;
  import pong_pkg::*;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int LOCKN = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  sync_data_t sync_s = '{h_sync: 1'b1, v_sync: 1'b1, video_on: 1'b0};
  logic [9:0] pos_x_o, pos_y_o;
  logic       pos_valid_o, frame_start_o, locked_o, h_len_err_o, v_len_err_o, de_err_o;
  logic [7:0] err_cnt_o;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(LOCKN)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pix_en_i(pix_en), .sync_i(sync_s),
    .pos_x_o(pos_x_o), .pos_y_o(pos_y_o), .pos_valid_o(pos_valid_o),
    .frame_start_o(frame_start_o), .locked_o(locked_o),
    .h_len_err_o(h_len_err_o), .v_len_err_o(v_len_err_o), .de_err_o(de_err_o),
    .err_cnt_o(err_cnt_o)
  );

  int n_chk = 0, n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: positions are line/frame distances since the last sync
  // leading edge; lock status follows the acquisition rules as plain integers.
  int m_hc, m_vc, m_state, m_good;   // m_state: 0 unlocked, 1 acquiring, 2 locked
  bit m_hprev, m_vprev;
  int exp_x, exp_y, exp_err;
  bit exp_valid, exp_fs, exp_locked, exp_herr, exp_verr, exp_de;

  task automatic model(input bit rst, input bit pen, input bit h, input bit v, input bit de);
    bit hact, vact, he, ve, herr, verr, vis;
    int x, y;
    if (rst) begin
      m_hc = 0; m_vc = 0; m_state = 0; m_good = 0; m_hprev = 0; m_vprev = 0;
      exp_x = 0; exp_y = 0; exp_err = 0;
      exp_valid = 0; exp_fs = 0; exp_locked = 0; exp_herr = 0; exp_verr = 0; exp_de = 0;
      return;
    end
    exp_fs = 0; exp_herr = 0; exp_verr = 0; exp_de = 0;
    if (!pen) return;
    hact = !h; vact = !v;
    he = hact && !m_hprev;
    m_hprev = hact;
    ve = 0; herr = 0; verr = 0;
    if (he) begin
      herr = (m_state != 0) && (m_hc + 1 != HT);
      m_hc = 0;
      ve = vact && !m_vprev;
      m_vprev = vact;
      if (ve) begin
        verr = (m_state != 0) && (m_vc + 1 != VT);
        m_vc = 0;
      end else if (m_vc < 2047) m_vc++;
    end else if (m_hc < 2047) m_hc++;
    if (m_state == 0) begin
      if (ve) begin m_state = 1; m_good = 0; end
    end else if (herr || verr) m_state = 0;
    else if (m_state == 1 && ve) begin
      m_good++;
      if (m_good == LOCKN) m_state = 2;
    end
    x = m_hc - (HS + HB);
    y = m_vc - (VS + VB);
    vis = (x >= 0) && (x < HV) && (y >= 0) && (y < VV);
    exp_locked = (m_state == 2);
    exp_x = x; exp_y = y;
    exp_valid = exp_locked && vis;
    exp_fs = exp_locked && (x == 0) && (y == 0);
    exp_de = exp_locked && (de != vis);
    exp_herr = herr; exp_verr = verr;
    exp_err = exp_err + int'(herr) + int'(verr) + int'(exp_de);
    if (exp_err > 255) exp_err = 255;
  endtask

  int fs_total = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_on) begin
        chk("locked", locked_o, exp_locked);
        chk("pos_valid", pos_valid_o, exp_valid);
        chk("frame_start", frame_start_o, exp_fs);
        chk("h_len_err", h_len_err_o, exp_herr);
        chk("v_len_err", v_len_err_o, exp_verr);
        chk("de_err", de_err_o, exp_de);
        chk("err_cnt", err_cnt_o, exp_err);
        if (exp_valid) begin
          chk("pos_x", pos_x_o, exp_x);
          chk("pos_y", pos_y_o, exp_y);
        end
        if (frame_start_o) fs_total++;
      end
    end
  end

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      rst_n = 0; pix_en = 0;
      model(1, 0, 1, 1, 0);
      chk_on = 1;
    end
    @(negedge clk);
    rst_n = 1; pix_en = 0;
    model(0, 0, 1, 1, 0);
  endtask

  // One pixel: a pix_en clk followed by an idle clk; returns with outputs of the pix_en tick.
  task automatic tick(input bit h, input bit v, input bit de);
    @(negedge clk);
    pix_en = 1;
    sync_s = '{h_sync: h, v_sync: v, video_on: de};
    model(0, 1, h, v, de);
    @(negedge clk);
    pix_en = 0;
    model(0, 0, h, v, de);
  endtask

  int kill_x = -1, kill_y = -1, de_inv_left = 0;
  int n_valid, n_h, n_v, n_de, fs_start, fx, fy, ffs, lx, ly;
  bit first_seen, f0_locked, f0_herr, f0_verr;
  int f0_err;

  task automatic send_frame(input int nlines, input int short_line, input int rst_line);
    int len, x, y;
    bit h, v, de;
    n_valid = 0; n_h = 0; n_v = 0; n_de = 0; fs_start = fs_total; first_seen = 0;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        if (l == rst_line && p == HT / 2) begin
          do_reset(1);
          chk("rst_locked", locked_o, 0);
          chk("rst_valid", pos_valid_o, 0);
          chk("rst_pos_x", pos_x_o, 0);
          chk("rst_pos_y", pos_y_o, 0);
          chk("rst_err_cnt", err_cnt_o, 0);
          chk("rst_pulses", {h_len_err_o, v_len_err_o, de_err_o, frame_start_o}, 0);
        end
        x = p - (HS + HB);
        y = l - (VS + VB);
        h = (p >= HS);
        v = (l >= VS);
        de = (x >= 0) && (x < HV) && (y >= 0) && (y < VV);
        if (x == kill_x && y == kill_y) de = 0;
        if (de_inv_left > 0) begin de = !de; de_inv_left--; end
        tick(h, v, de);
        if (l == 0 && p == 0) begin
          f0_locked = locked_o; f0_herr = h_len_err_o; f0_verr = v_len_err_o; f0_err = err_cnt_o;
        end
        if (pos_valid_o) begin
          n_valid++;
          if (!first_seen) begin
            fx = pos_x_o; fy = pos_y_o; ffs = frame_start_o; first_seen = 1;
          end
          lx = pos_x_o; ly = pos_y_o;
        end
        n_h += int'(h_len_err_o);
        n_v += int'(v_len_err_o);
        n_de += int'(de_err_o);
      end
    end
  endtask

  initial begin
    do_reset(3);
    chk("init_locked", locked_o, 0);
    chk("init_valid", pos_valid_o, 0);
    chk("init_err_cnt", err_cnt_o, 0);

    // Clean acquisition: locked at the start of the third frame.
    send_frame(VT, -1, -1);
    send_frame(VT, -1, -1);
    chk("acq_not_yet_locked", locked_o, 0);
    send_frame(VT, -1, -1);
    chk("lock_at_frame3", f0_locked, 1);
    chk("valid_count", n_valid, HV * VV);
    chk("first_x", fx, 0);
    chk("first_y", fy, 0);
    chk("first_fs", ffs, 1);
    chk("fs_one_clk", fs_total - fs_start, 1);
    chk("last_x", lx, HV - 1);
    chk("last_y", ly, VV - 1);

    // One short line while locked.
    send_frame(VT, 4, -1);
    chk("hshort_pulses", n_h, 1);
    chk("hshort_unlocked", locked_o, 0);
    chk("hshort_err_cnt", err_cnt_o, 1);
    send_frame(VT, -1, -1);
    send_frame(VT, -1, -1);
    chk("hshort_still_acq", locked_o, 0);
    send_frame(VT, -1, -1);
    chk("hshort_relock", f0_locked, 1);

    // Frame one line short while locked.
    send_frame(VT - 1, -1, -1);
    send_frame(VT, -1, -1);
    chk("vshort_pulse", f0_verr, 1);
    chk("vshort_no_h", f0_herr, 0);
    chk("vshort_unlocked", f0_locked, 0);
    send_frame(VT, -1, -1);
    send_frame(VT, -1, -1);

    // video_on dropped on one visible pixel.
    kill_x = 3; kill_y = 2;
    send_frame(VT, -1, -1);
    kill_x = -1; kill_y = -1;
    chk("de_relocked", f0_locked, 1);
    chk("de_pulses", n_de, 1);
    chk("de_keeps_lock", locked_o, 1);
    chk("de_err_cnt", err_cnt_o, 3);

    // Reset in the middle of a frame.
    send_frame(VT, -1, 5);
    chk("rst_no_len_err", n_h + n_v, 0);
    send_frame(VT, -1, -1);
    chk("rst_edge_no_err", {f0_herr, f0_verr}, 0);
    send_frame(VT, -1, -1);
    send_frame(VT, -1, -1);
    chk("rst_relock", f0_locked, 1);

    // Saturation: 254 video_on errors, then simultaneous h and v errors.
    de_inv_left = 254;
    send_frame(VT, -1, -1);
    send_frame(VT, -1, -1);
    chk("err_cnt_254", err_cnt_o, 254);
    send_frame(VT - 1, VT - 2, -1);
    send_frame(VT, -1, -1);
    chk("both_h", f0_herr, 1);
    chk("both_v", f0_verr, 1);
    chk("both_sat", f0_err, 255);
    send_frame(VT, 3, -1);
    chk("sat_h_pulse", n_h, 1);
    chk("sat_hold", err_cnt_o, 255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
